// File: rtl/dma_pkg.sv
// dma_pkg: port offsets, mode register layout and reset constants shared by the 8237A CPU port
package dma_pkg;
  typedef enum logic [3:0] {
    ADDR0, CNT0, ADDR1, CNT1, ADDR2, CNT2, ADDR3, CNT3,
    CMD_STAT, REQ, SMASK, MODE, CLR_PTR, MCLR_TEMP, CLR_MASK, ALL_MASK
  } port_t;
  typedef struct packed {
    logic [1:0] mode;
    logic       dec;
    logic       autoinit;
    logic [1:0] xfer;
  } mode_t;
  localparam logic [3:0] MASK_RESET = 4'hF;
  function automatic logic [7:0] pick_byte(input logic [15:0] w, input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction
endpackage

// File: rtl/dma_addr_latch.sv
// dma_addr_latch: ALE address capture and chip-select compare against the I/O page
module dma_addr_latch #(
  parameter logic [3:0] BASE = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ale,
  input  logic       hlda,
  input  logic [7:0] ad_lo,
  output logic [3:0] offset,
  output logic       sel
);
  logic [7:0] addr_lat, addr;
  always_ff @(posedge clk) addr_lat <= rst ? 8'h00 : ale ? ad_lo : addr_lat;
  // a strobe coincident with ALE decodes the address being latched this cycle
  assign addr = ale ? ad_lo : addr_lat;
  assign offset = addr[3:0];
  assign sel = (addr[7:4] == BASE) & ~hlda;
endmodule

// File: rtl/dma_cpu_port.sv
// dma_cpu_port: 8237A CPU register port; define DMA_REG_READBACK_EN to drive read data onto AD15_AD0
module dma_cpu_port
  import dma_pkg::*;
#(
  parameter logic [3:0] DMA_BASE = 4'h0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ALE,
  inout  wire  [15:0]      AD15_AD0,
  input  logic             nIOR,
  input  logic             nIOW,
  input  logic             Hlda,
  input  logic [3:0][15:0] CurAddr,
  input  logic [3:0][15:0] CurCount,
  input  logic [7:0]       Status,
  input  logic [7:0]       TempReg,
  output logic [7:0]       CmdReg,
  output logic [3:0][5:0]  ModeReg,
  output logic [3:0]       MaskReg,
  output logic [3:0]       ReqReg,
  output logic [3:0][15:0] BaseAddr,
  output logic [3:0][15:0] BaseCount,
  output logic [3:0]       LoadCh,
  output logic             MasterClr,
  output logic             StatusRd
);
  logic [3:0] offset;
  logic [1:0] ch;
  logic [7:0] d, rd_data;
  logic       sel, iow_q, ior_q, post_rst, byte_ptr, wr, rd;
  port_t      port;
  mode_t      mode_wr;
  dma_addr_latch #(.BASE(DMA_BASE)) u_lat (
    .clk(Clock), .rst(Reset), .ale(ALE), .hlda(Hlda),
    .ad_lo(AD15_AD0[7:0]), .offset(offset), .sel(sel)
  );
  assign port = port_t'(offset);
  assign ch = offset[2:1];
  assign d = AD15_AD0[15:8];
  assign mode_wr = mode_t'(d[7:2]);
  // post_rst blocks a strobe that was already low while Reset was asserted
  assign wr = ~nIOW & iow_q & sel & ~post_rst;
  assign rd = ~nIOR & ior_q & sel & ~post_rst;
  assign rd_data = ~offset[3] ? pick_byte(offset[0] ? CurCount[ch] : CurAddr[ch], byte_ptr)
                 : port == CMD_STAT ? Status : port == MCLR_TEMP ? TempReg : 8'hFF;
`ifdef DMA_REG_READBACK_EN
  localparam logic RB = 1'b1;
  assign AD15_AD0 = (~Reset & ~nIOR & sel) ? {rd_data, 8'hzz} : 16'hzzzz;
`else
  localparam logic RB = 1'b0;
  logic unused_rd;
  assign unused_rd = ^rd_data;
  assign AD15_AD0 = 16'hzzzz;
`endif
  always_ff @(posedge Clock) begin
    iow_q <= Reset | nIOW;
    ior_q <= Reset | nIOR;
    post_rst <= Reset;
    if (Reset) begin
      CmdReg <= 8'h00;
      ModeReg <= '0;
      MaskReg <= MASK_RESET;
      ReqReg <= 4'h0;
      BaseAddr <= '0;
      BaseCount <= '0;
      LoadCh <= 4'h0;
      MasterClr <= 1'b0;
      StatusRd <= 1'b0;
      byte_ptr <= 1'b0;
    end else begin
      LoadCh <= 4'h0;
      MasterClr <= 1'b0;
      StatusRd <= RB & rd & (port == CMD_STAT);
      if (rd && !offset[3]) byte_ptr <= ~byte_ptr;
      if (wr) begin
        case (port)
          CMD_STAT:  CmdReg <= d;
          REQ:       ReqReg[d[1:0]] <= d[2];
          SMASK:     MaskReg[d[1:0]] <= d[2];
          MODE:      ModeReg[d[1:0]] <= mode_wr;
          CLR_PTR:   byte_ptr <= 1'b0;
          MCLR_TEMP: begin
            CmdReg <= 8'h00;
            ReqReg <= 4'h0;
            MaskReg <= MASK_RESET;
            byte_ptr <= 1'b0;
            MasterClr <= 1'b1;
          end
          CLR_MASK:  MaskReg <= 4'h0;
          ALL_MASK:  MaskReg <= d[3:0];
          default: begin
            if (offset[0]) BaseCount[ch][{byte_ptr, 3'b000} +: 8] <= d;
            else BaseAddr[ch][{byte_ptr, 3'b000} +: 8] <= d;
            LoadCh[ch] <= 1'b1;
            byte_ptr <= ~byte_ptr;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dma_cpu_port.sv
// tb_dma_cpu_port: vector table plus scoreboarded bus reads and corner-case sequences for dma_cpu_port
module tb_dma_cpu_port;
  localparam logic [3:0] BASE = 4'h0;
`ifdef DMA_REG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  typedef enum {OP_W, OP_R, OP_N} op_e;
  typedef enum {P_NONE, P_BA0, P_BA3, P_BC1, P_MODE, P_CMD, P_MASK, P_REQ, P_LD0, P_MCLR, P_SRD} probe_e;
  typedef struct {
    op_e         op;
    logic [3:0]  off;
    logic [7:0]  d;
    probe_e      p;
    logic [23:0] exp;
  } vec_t;
  logic clk = 0, rst = 1, ale = 0, nior = 1, niow = 1, hlda = 0, hi_en = 0;
  logic [7:0] lo = 8'h00, hi = 8'h00, status = 8'h5A, temp = 8'h3C;
  logic [3:0][15:0] cur_addr, cur_cnt, base_addr, base_cnt;
  logic [7:0] cmd_reg;
  logic [3:0][5:0] mode_reg;
  logic [3:0] mask_reg, req_reg, load_ch;
  logic master_clr, status_rd;
  wire [15:0] ad;
  int checks = 0, errors = 0, load0_cnt = 0, mclr_cnt = 0, srd_cnt = 0;
  vec_t vec[$];
  logic [7:0] exp_q[$];
  assign cur_addr = {16'hDEF0, 16'h9ABC, 16'h2468, 16'h1357};
  assign cur_cnt = {16'h4B5A, 16'hABCD, 16'h2D3C, 16'h0F1E};
  assign ad = {hi_en ? hi : 8'hzz, lo};
  for (genvar g = 8; g < 16; g++) begin : g_pu
    pullup (ad[g]);
  end
  dma_cpu_port #(.DMA_BASE(BASE)) dut (
    .Clock(clk), .Reset(rst), .ALE(ale), .AD15_AD0(ad), .nIOR(nior), .nIOW(niow), .Hlda(hlda),
    .CurAddr(cur_addr), .CurCount(cur_cnt), .Status(status), .TempReg(temp),
    .CmdReg(cmd_reg), .ModeReg(mode_reg), .MaskReg(mask_reg), .ReqReg(req_reg),
    .BaseAddr(base_addr), .BaseCount(base_cnt), .LoadCh(load_ch),
    .MasterClr(master_clr), .StatusRd(status_rd)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    load0_cnt += int'(load_ch[0]);
    mclr_cnt += int'(master_clr);
    srd_cnt += int'(status_rd);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string nm, input logic [23:0] act, input logic [23:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, want);
    end
  endtask
  function automatic logic [23:0] probe(input probe_e p);
    case (p)
      P_BA0:  return {8'h00, base_addr[0]};
      P_BA3:  return {8'h00, base_addr[3]};
      P_BC1:  return {8'h00, base_cnt[1]};
      P_MODE: return mode_reg;
      P_CMD:  return {16'h0, cmd_reg};
      P_MASK: return {20'h0, mask_reg};
      P_REQ:  return {20'h0, req_reg};
      P_LD0:  return 24'(load0_cnt);
      P_MCLR: return 24'(mclr_cnt);
      P_SRD:  return 24'(srd_cnt);
      default: return 24'h0;
    endcase
  endfunction
  function automatic logic [7:0] rbv(input logic [7:0] v);
    return RB ? v : 8'hFF;
  endfunction
  task automatic add(input op_e op, input logic [3:0] off, input logic [7:0] d, input probe_e p, input logic [23:0] e);
    vec.push_back('{op, off, d, p, e});
  endtask
  task automatic bus_write(input logic [3:0] o, input logic [7:0] v, input int len);
    ale = 1; lo = {BASE, o};
    cyc();
    ale = 0; hi = v; hi_en = 1; niow = 0;
    repeat (len) cyc();
    niow = 1; hi_en = 0;
    cyc();
  endtask
  task automatic bus_read(input logic [3:0] o, input logic [7:0] e, input string nm);
    ale = 1; lo = {BASE, o};
    cyc();
    ale = 0;
    exp_q.push_back(e);
    nior = 0;
    @(negedge clk);
    check(nm, {16'h0, ad[15:8]}, {16'h0, exp_q.pop_front()});
    @(posedge clk);
    #1;
    nior = 1;
    cyc();
  endtask
  initial begin
    add(OP_W, 4'd0,  8'h34, P_BA0,  24'h001234 & 24'h0000FF);
    add(OP_W, 4'd0,  8'h12, P_BA0,  24'h001234);
    add(OP_N, 4'd0,  8'h00, P_LD0,  24'd2);
    add(OP_W, 4'd11, 8'h49, P_MODE, 24'h000480);
    add(OP_W, 4'd8,  8'hA5, P_CMD,  24'h0000A5);
    add(OP_W, 4'd10, 8'h02, P_MASK, 24'h00000B);
    add(OP_W, 4'd9,  8'h07, P_REQ,  24'h000008);
    add(OP_W, 4'd9,  8'h05, P_REQ,  24'h00000A);
    add(OP_W, 4'd14, 8'h00, P_MASK, 24'h000000);
    add(OP_W, 4'd15, 8'h3C, P_MASK, 24'h00000C);
    add(OP_W, 4'd3,  8'h78, P_BC1,  24'h000078);
    add(OP_W, 4'd12, 8'h00, P_BC1,  24'h000078);
    add(OP_W, 4'd3,  8'h56, P_BC1,  24'h000056);
    add(OP_W, 4'd12, 8'h00, P_BC1,  24'h000056);
    add(OP_R, 4'd5,  8'h00, P_NONE, {16'h0, rbv(8'hCD)});
    add(OP_R, 4'd5,  8'h00, P_NONE, {16'h0, rbv(8'hAB)});
    add(OP_R, 4'd8,  8'h00, P_NONE, {16'h0, rbv(8'h5A)});
    add(OP_N, 4'd0,  8'h00, P_SRD,  RB ? 24'd1 : 24'd0);
    add(OP_R, 4'd13, 8'h00, P_NONE, {16'h0, rbv(8'h3C)});
    add(OP_R, 4'd14, 8'h00, P_NONE, 24'h0000FF);
    add(OP_R, 4'd0,  8'h00, P_NONE, {16'h0, rbv(8'h57)});
    add(OP_W, 4'd6,  8'h11, P_BA3,  24'h001100);
    add(OP_W, 4'd13, 8'h00, P_CMD,  24'h000000);
    add(OP_N, 4'd0,  8'h00, P_MASK, 24'h00000F);
    add(OP_N, 4'd0,  8'h00, P_REQ,  24'h000000);
    add(OP_N, 4'd0,  8'h00, P_MODE, 24'h000480);
    add(OP_N, 4'd0,  8'h00, P_MCLR, 24'd1);
    add(OP_N, 4'd0,  8'h00, P_BA0,  24'h001234);
    add(OP_N, 4'd0,  8'h00, P_LD0,  24'd2);
    repeat (2) cyc();
    rst = 0;
    check("rst_mask", probe(P_MASK), 24'h00000F);
    check("rst_cmd", probe(P_CMD), 24'h0);
    check("rst_req", probe(P_REQ), 24'h0);
    check("rst_mode", probe(P_MODE), 24'h0);
    check("rst_ba0", probe(P_BA0), 24'h0);
    check("rst_pulses", {21'h0, load_ch != 4'h0, master_clr, status_rd}, 24'h0);
    check("rst_ad", {16'h0, ad[15:8]}, 24'h0000FF);
    foreach (vec[i]) begin
      case (vec[i].op)
        OP_W: bus_write(vec[i].off, vec[i].d, 1);
        OP_R: bus_read(vec[i].off, vec[i].exp[7:0], $sformatf("v%0d_rd", i));
        default: ;
      endcase
      if (vec[i].op != OP_R) check($sformatf("v%0d_%s", i, vec[i].p.name()), probe(vec[i].p), vec[i].exp);
    end
    bus_write(4'd0, 8'hAA, 4);
    check("long_wr_ba0", probe(P_BA0), 24'h0012AA);
    check("long_wr_ld0", probe(P_LD0), 24'd3);
    bus_write(4'd0, 8'hBB, 1);
    check("ptr_once_ba0", probe(P_BA0), 24'h00BBAA);
    hlda = 1;
    bus_write(4'd8, 8'hFF, 1);
    check("hlda_cmd", probe(P_CMD), 24'h0);
    bus_read(4'd13, 8'hFF, "hlda_rd_ad");
    hlda = 0;
    ale = 1; lo = {BASE, 4'd8};
    cyc();
    ale = 0;
    exp_q.push_back(rbv(8'h5A));
    nior = 0;
    @(negedge clk);
    check("mid_hlda_pre", {16'h0, ad[15:8]}, {16'h0, exp_q.pop_front()});
    hlda = 1;
    #1;
    check("mid_hlda_ad", {16'h0, ad[15:8]}, 24'h0000FF);
    @(posedge clk);
    #1;
    nior = 1; hlda = 0;
    cyc();
    check("mid_hlda_srd", probe(P_SRD), RB ? 24'd1 : 24'd0);
    ale = 1; lo = {BASE, 4'd8};
    cyc();
    ale = 0; hi = 8'h77; hi_en = 1; niow = 0; rst = 1;
    cyc();
    rst = 0;
    repeat (2) cyc();
    niow = 1; hi_en = 0;
    cyc();
    check("rst_strobe_cmd", probe(P_CMD), 24'h0);
    check("rst_strobe_ba0", probe(P_BA0), 24'h0);
    ale = 1; lo = {BASE, 4'd8};
    cyc();
    lo = {BASE, 4'd15}; hi = 8'h05; hi_en = 1; niow = 0;
    cyc();
    ale = 0; niow = 1; hi_en = 0;
    cyc();
    check("ale_coinc_mask", probe(P_MASK), 24'h000005);
    check("ale_coinc_cmd", probe(P_CMD), 24'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
